// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: parity modes, receiver state encoding, bit-centre helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  function automatic int unsigned mid_of(input int unsigned oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver line/config inputs and valid-ready output bundle; master = receiver, slave = consumer.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 oversample_tick;
  logic                 rxd;
  logic [1:0]           cfg_parity;
  logic [DATA_BITS-1:0] data_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 parity_error;
  logic                 stop_error;
  logic                 break_detect;
  logic                 overrun_error;

  modport master (
    input  oversample_tick, rxd, cfg_parity, out_ready,
    output data_out, out_valid, parity_error, stop_error, break_detect, overrun_error
  );

  modport slave (
    output oversample_tick, rxd, cfg_parity, out_ready,
    input  data_out, out_valid, parity_error, stop_error, break_detect, overrun_error
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// 2-FF rxd synchroniser plus majority vote over the three samples around the bit centre.
// vote is valid on the decision tick (phase MID+1), combining two stored samples with the live one.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int PH_W       = $clog2(OVERSAMPLE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            rxd,
  input  logic [PH_W-1:0] phase,
  output logic            rxs,
  output logic            vote
);

  localparam int MID = int'(mid_of(OVERSAMPLE));
  localparam logic [PH_W-1:0] PH_MIDM1 = PH_W'(MID - 1);
  localparam logic [PH_W-1:0] PH_MID   = PH_W'(MID);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] smp_q, smp_d;

  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    smp_d   = smp_q;
    if (tick && (phase == PH_MIDM1 || phase == PH_MID)) begin
      smp_d = {smp_q[0], sync2_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      smp_q   <= 2'b11;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      smp_q   <= smp_d;
    end
  end

  assign rxs  = sync2_q;
  assign vote = (smp_q[1] & smp_q[0]) | (smp_q[1] & sync2_q) | (smp_q[0] & sync2_q);

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with parity/stop checking, break detection and a one-deep valid/ready output.
// Frame registers at the final stop decision tick; a completion while a frame is held and not accepted is dropped with overrun_error.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_param_if.master rx
);

  localparam int MID  = int'(mid_of(OVERSAMPLE));
  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int BI_W = 4;
  localparam logic [PH_W-1:0] PH_DEC  = PH_W'(MID + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  rx_state_t            state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [BI_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 par_acc_q, par_acc_d;
  logic                 perr_q, perr_d;
  logic                 serr_q, serr_d;
  logic                 zero_q, zero_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 vld_q, vld_d;
  logic                 pe_q, pe_d;
  logic                 se_q, se_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;

  logic rxs, vote, dec, wrap, complete, is_brk, frame_se;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .PH_W(PH_W)) u_sampler (
    .clk   (clk),
    .reset (reset),
    .tick  (rx.oversample_tick),
    .rxd   (rx.rxd),
    .phase (phase_q),
    .rxs   (rxs),
    .vote  (vote)
  );

  assign dec  = rx.oversample_tick && (phase_q == PH_DEC);
  assign wrap = rx.oversample_tick && (phase_q == PH_LAST);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    par_acc_d  = par_acc_q;
    perr_d     = perr_q;
    serr_d     = serr_q;
    zero_d     = zero_q;
    complete   = 1'b0;
    is_brk     = 1'b0;
    frame_se   = serr_q;

    if (rx.oversample_tick) begin
      phase_d = wrap ? '0 : phase_q + PH_W'(1);
    end

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (rx.oversample_tick && !rxs) begin
          state_d    = START;
          bit_d      = '0;
          par_mode_d = rx.cfg_parity;
          par_acc_d  = 1'b0;
          perr_d     = 1'b0;
          serr_d     = 1'b0;
          zero_d     = 1'b1;
        end
      end
      START: begin
        if (dec && vote) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (dec) begin
          shift_d   = {vote, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ vote;
          zero_d    = zero_q & ~vote;
        end
        if (wrap) begin
          if (bit_q == BI_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (par_mode_q == PAR_EVEN || par_mode_q == PAR_ODD) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BI_W'(1);
          end
        end
      end
      PARITY: begin
        if (dec) begin
          perr_d = (par_mode_q == PAR_ODD) ? ~(par_acc_q ^ vote) : (par_acc_q ^ vote);
          zero_d = zero_q & ~vote;
        end
        if (wrap) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (dec) begin
          frame_se = serr_q | ~vote;
          serr_d   = frame_se;
          // Completing at the last decision lets a back-to-back start edge be caught.
          if (bit_q == BI_W'(STOP_BITS - 1)) begin
            complete = 1'b1;
            is_brk   = zero_q & ~vote;
            state_d  = is_brk ? BREAK_WAIT : IDLE;
          end
        end
        if (wrap) begin
          bit_d = bit_q + BI_W'(1);
        end
      end
      BREAK_WAIT: begin
        phase_d = '0;
        if (rx.oversample_tick && rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    pe_d   = pe_q;
    se_d   = se_q;
    vld_d  = vld_q & ~rx.out_ready;
    brk_d  = complete & is_brk;
    ovr_d  = 1'b0;
    if (complete && !is_brk) begin
      if (vld_q && !rx.out_ready) begin
        ovr_d = 1'b1;
      end else begin
        vld_d  = 1'b1;
        dout_d = shift_q;
        pe_d   = perr_q;
        se_d   = frame_se;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_mode_q <= PAR_NONE;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      zero_q     <= 1'b0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      par_acc_q  <= par_acc_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      zero_q     <= zero_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx.data_out      = dout_q;
  assign rx.out_valid     = vld_q;
  assign rx.parity_error  = pe_q;
  assign rx.stop_error    = se_q;
  assign rx.break_detect  = brk_q;
  assign rx.overrun_error = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: two receivers (1 and 2 stop bits) share one serial line; accepted frames are checked against queued expectations.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clk

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       se;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       rxd;
  logic       hide1;
  logic       out_ready;
  logic [1:0] cfg;

  exp_t q1[$];
  exp_t q2[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   brk1 = 0, brk2 = 0, ovr1 = 0, ovr2 = 0;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_if #(.DATA_BITS(8)) if2 ();

  assign if1.oversample_tick = tick;
  assign if1.rxd             = rxd | hide1;
  assign if1.cfg_parity      = cfg;
  assign if1.out_ready       = out_ready;
  assign if2.oversample_tick = tick;
  assign if2.rxd             = rxd;
  assign if2.cfg_parity      = cfg;
  assign if2.out_ready       = out_ready;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .rx    (if1.master)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .rx    (if2.master)
  );

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic check_pop(input int id, input exp_t got);
    exp_t e;
    n_cmp++;
    if ((id == 1 && q1.size() == 0) || (id == 2 && q2.size() == 0)) begin
      n_bad++;
      $display("FAIL unexpected_frame dut%0d: got data=%h pe=%b se=%b, required no frame",
               id, got.d, got.pe, got.se);
    end else begin
      if (id == 1) e = q1.pop_front();
      else         e = q2.pop_front();
      if (got !== e) begin
        n_bad++;
        $display("FAIL frame dut%0d: got data=%h pe=%b se=%b, required data=%h pe=%b se=%b",
                 id, got.d, got.pe, got.se, e.d, e.pe, e.se);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (if1.out_valid && if1.out_ready)
        check_pop(1, {if1.data_out, if1.parity_error, if1.stop_error});
      if (if2.out_valid && if2.out_ready)
        check_pop(2, {if2.data_out, if2.parity_error, if2.stop_error});
      if (if1.break_detect)  brk1++;
      if (if2.break_detect)  brk2++;
      if (if1.overrun_error) ovr1++;
      if (if2.overrun_error) ovr2++;
    end
  end

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic pbit,
                            input logic s1, input logic s2, input logic h1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par_en) send_bit(pbit);
    send_bit(s1);
    hide1 = h1;
    send_bit(s2);
    hide1 = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic exp_both(input logic [7:0] d, input logic pe, input logic se1, input logic se2);
    q1.push_back({d, pe, se1});
    q2.push_back({d, pe, se2});
  endtask

  initial begin
    logic [7:0] rdat;
    reset     = 1'b1;
    rxd       = 1'b1;
    hide1     = 1'b0;
    out_ready = 1'b1;
    cfg       = PAR_NONE;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data_out",  32'(if1.data_out), 32'h0);
    chk("rst_out_valid", 32'(if1.out_valid), 32'h0);
    chk("rst_par_err",   32'(if1.parity_error), 32'h0);
    chk("rst_stop_err",  32'(if1.stop_error), 32'h0);
    chk("rst_break",     32'(if1.break_detect), 32'h0);
    chk("rst_overrun",   32'(if1.overrun_error), 32'h0);
    chk("rst_valid2",    32'(if2.out_valid), 32'h0);
    reset = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);

    exp_both(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // 0x03 has even weight: even mode flags a set parity bit, odd mode accepts it.
    cfg = PAR_EVEN;
    exp_both(8'h03, 1'b1, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_both(8'h03, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cfg = PAR_ODD;
    exp_both(8'h03, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cfg = PAR_NONE;

    rxd = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    repeat (3) send_bit(1'b1);
    chk("glitch_idle1", 32'(u_dut1.state_q), 32'(IDLE));
    chk("glitch_idle2", 32'(u_dut2.state_q), 32'(IDLE));
    exp_both(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    exp_both(8'h3C, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_both(8'h96, 1'b0, 1'b0, 1'b1);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    rxd = 1'b0;
    repeat (30 * BIT_CLKS) @(posedge clk);
    #1;
    chk("break_pulses1", 32'(brk1), 32'd1);
    chk("break_pulses2", 32'(brk2), 32'd1);
    send_bit(1'b1);
    send_bit(1'b1);
    exp_both(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    out_ready = 1'b0;
    exp_both(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("held_valid1", 32'(if1.out_valid), 32'h1);
    chk("held_data1",  32'(if1.data_out), 32'h11);
    chk("held_valid2", 32'(if2.out_valid), 32'h1);
    chk("held_data2",  32'(if2.data_out), 32'h11);
    chk("overrun_pulses1", 32'(ovr1), 32'd1);
    chk("overrun_pulses2", 32'(ovr2), 32'd1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("accepted_valid1", 32'(if1.out_valid), 32'h0);

    rdat = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(rdat[i]);
    rxd = rdat[3];
    repeat (BIT_CLKS / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_data_out", 32'(if1.data_out), 32'h0);
    chk("midrst_valid",    32'(if1.out_valid), 32'h0);
    chk("midrst_par_err",  32'(if1.parity_error), 32'h0);
    chk("midrst_stop_err", 32'(if1.stop_error), 32'h0);
    chk("midrst_data2",    32'(if2.data_out), 32'h0);
    reset = 1'b0;
    repeat (12) send_bit(1'b1);
    chk("post_rst_valid1", 32'(if1.out_valid), 32'h0);
    chk("post_rst_valid2", 32'(if2.out_valid), 32'h0);

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("break_total1", 32'(brk1), 32'd1);
    chk("overrun_total1", 32'(ovr1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
